// File: rtl/move_cost_gen.sv
// move_cost_gen: walks the 8 ball neighbours, looks up used edges and registers a distance-to-goal cost per direction
module move_cost_gen #(
  parameter int BOARD_W = 9,
  parameter int BOARD_H = 11,
  parameter int GOAL_X  = 4,
  parameter int GOAL_Y  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pos_x,
  input  logic [3:0] pos_y,
  output logic       edge_rd_en,
  output logic [3:0] edge_rd_x,
  output logic [3:0] edge_rd_y,
  output logic [2:0] edge_rd_dir,
  input  logic       edge_used,
  output logic       busy,
  output logic       done,
  output logic       no_move,
  output logic [7:0] cost_0,
  output logic [7:0] cost_1,
  output logic [7:0] cost_2,
  output logic [7:0] cost_3,
  output logic [7:0] cost_4,
  output logic [7:0] cost_5,
  output logic [7:0] cost_6,
  output logic [7:0] cost_7
);
  localparam logic signed [5:0] BW = 6'(BOARD_W);
  localparam logic signed [5:0] BH = 6'(BOARD_H);
  localparam logic signed [5:0] GX = 6'(GOAL_X);
  localparam logic signed [5:0] GY = 6'(GOAL_Y);
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;
  state_t state;
  logic [3:0] px, py;
  logic [2:0] dir;
  logic [4:0] nb, nxt;
  logic [7:0][7:0] cost;
  logic [7:0] cur_cost;
  // returns {on_field, chebyshev distance to goal}
  function automatic logic [4:0] probe(input logic [3:0] x, input logic [3:0] y, input logic [2:0] d);
    logic signed [5:0] dx, dy, nx, ny, ex, ey;
    dx = (d >= 3'd1 && d <= 3'd3) ? 6'sd1 : (d >= 3'd5) ? -6'sd1 : 6'sd0;
    dy = (d == 3'd0 || d == 3'd1 || d == 3'd7) ? -6'sd1 : (d >= 3'd3 && d <= 3'd5) ? 6'sd1 : 6'sd0;
    nx = $signed({2'b00, x}) + dx;
    ny = $signed({2'b00, y}) + dy;
    ex = nx - GX;
    ey = ny - GY;
    ex = (ex < 6'sd0) ? -ex : ex;
    ey = (ey < 6'sd0) ? -ey : ey;
    probe = {nx >= 6'sd0 && nx < BW && ny >= 6'sd0 && ny < BH, 4'(ex > ey ? ex : ey)};
  endfunction
  always_comb begin
    nxt = (state == IDLE) ? probe(pos_x, pos_y, 3'd0) : probe(px, py, dir + 3'd1);
    cur_cost = (nb[4] && !edge_used) ? {4'h0, nb[3:0]} : 8'hFF;
  end
  assign edge_rd_x = px;
  assign edge_rd_y = py;
  assign edge_rd_dir = dir;
  assign {cost_7, cost_6, cost_5, cost_4, cost_3, cost_2, cost_1, cost_0} = cost;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      px <= '0;
      py <= '0;
      dir <= '0;
      nb <= '0;
      cost <= '1;
      busy <= 1'b0;
      done <= 1'b0;
      no_move <= 1'b1;
      edge_rd_en <= 1'b0;
    end else begin
      done <= 1'b0;
      edge_rd_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          px <= pos_x;
          py <= pos_y;
          dir <= '0;
          nb <= nxt;
          edge_rd_en <= nxt[4];
          cost <= '1;
          busy <= 1'b1;
          no_move <= 1'b1;
        end
        ISSUE: state <= CHECK;
        CHECK: begin
          cost[dir] <= cur_cost;
          if (dir == 3'd7) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            no_move <= (&cost[6:0]) && cur_cost == 8'hFF;
          end else begin
            state <= ISSUE;
            dir <= dir + 3'd1;
            nb <= nxt;
            edge_rd_en <= nxt[4];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
